// File: rtl/alu_serial_sequencer.sv
// Bit-serial ALU sequencer: walks one external 1-bit slice
// LSB first and assembles the word result and flags.
module alu_serial_sequencer #(
  parameter int WIDTH = 32,
  parameter int IDXW  = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       command,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_carryin,
  output logic [2:0]       slice_command,
  input  logic             slice_result,
  input  logic             slice_carryout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_SLTFIX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [2:0]       r_cmd;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;
  logic             r_co;
  logic             r_ov;
  logic             r_zero;

  logic             w_last;
  logic             w_arith;
  logic             w_is_slt;
  logic             w_sub_in;
  logic [WIDTH-1:0] w_final;
  logic             w_slt_bit;

  // Operands shift right so bit 0 is always the current bit;
  // the result fills from the top and lands aligned after WIDTH bits.
  assign w_last    = (r_idx == IDXW'(WIDTH - 1));
  assign w_is_slt  = (r_cmd == 3'b011);
  assign w_arith   = (r_cmd == 3'b000) || (r_cmd == 3'b001) || w_is_slt;
  assign w_sub_in  = (command == 3'b001) || (command == 3'b011);
  assign w_final   = {slice_result, r_res[WIDTH-1:1]};
  assign w_slt_bit = r_res[WIDTH-1] ^ r_ov;

  assign result   = r_res;
  assign carryout = r_co;
  assign overflow = r_ov;
  assign zero     = r_zero;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and slice/handshake outputs
  always_comb begin
    w_next        = r_state;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    slice_a       = 1'b0;
    slice_b       = 1'b0;
    slice_carryin = 1'b0;
    slice_command = 3'b000;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_RUN;
      end
      S_RUN: begin
        slice_a       = r_a[0];
        slice_b       = r_b[0];
        slice_carryin = r_carry;
        slice_command = r_cmd;
        if (w_last) w_next = w_is_slt ? S_SLTFIX : S_DONE;
      end
      S_SLTFIX: begin
        w_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Operand latch, per-bit capture, flags and SLT fix-up
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_cmd   <= 3'b000;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_co    <= 1'b0;
      r_ov    <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_cmd   <= command;
            r_idx   <= '0;
            r_carry <= w_sub_in;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_res   <= w_final;
          r_carry <= slice_carryout;
          if (!w_last) begin
            r_idx <= r_idx + 1'b1;
          end else begin
            r_co   <= w_arith & slice_carryout;
            r_ov   <= w_arith & (r_carry ^ slice_carryout);
            r_zero <= (w_final == '0);
          end
        end
        S_SLTFIX: begin
          r_res  <= {{(WIDTH-1){1'b0}}, w_slt_bit};
          r_zero <= ~w_slt_bit;
        end
        S_DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Scoreboard bench for alu_serial_sequencer with a
// behavioural 1-bit slice and a word-level reference model.
module tb_alu_serial_sequencer;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] r;
    logic         co;
    logic         ov;
    logic         z;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   command;
  logic         slice_a;
  logic         slice_b;
  logic         slice_carryin;
  logic [2:0]   slice_command;
  logic         slice_result;
  logic         slice_carryout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carryout;
  logic         overflow;
  logic         zero;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_serial_sequencer #(.WIDTH(W), .IDXW(6)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .a              (a),
    .b              (b),
    .command        (command),
    .slice_a        (slice_a),
    .slice_b        (slice_b),
    .slice_carryin  (slice_carryin),
    .slice_command  (slice_command),
    .slice_result   (slice_result),
    .slice_carryout (slice_carryout),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .result         (result),
    .carryout       (carryout),
    .overflow       (overflow),
    .zero           (zero)
  );

  // External 1-bit ALU slice; inverts B for SUB and SLT
  logic w_bb;
  always_comb begin
    w_bb           = slice_b ^ ((slice_command == 3'b001) ||
                                (slice_command == 3'b011));
    slice_result   = 1'b0;
    slice_carryout = 1'b0;
    case (slice_command)
      3'b000, 3'b001, 3'b011: begin
        slice_result   = slice_a ^ w_bb ^ slice_carryin;
        slice_carryout = (slice_a & w_bb) |
                         (slice_carryin & (slice_a ^ w_bb));
      end
      3'b010: slice_result = slice_a ^ slice_b;
      3'b100: slice_result = slice_a & slice_b;
      3'b101: slice_result = ~(slice_a & slice_b);
      3'b110: slice_result = ~(slice_a | slice_b);
      default: slice_result = slice_a | slice_b;
    endcase
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic is_arith(input logic [2:0] c);
    return (c == 3'b000) || (c == 3'b001) || (c == 3'b011);
  endfunction

  // Word-level reference: plain two's-complement arithmetic
  function automatic exp_t model(input logic [2:0] c,
                                 input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    exp_t       e;
    logic [W:0] s;
    e = '0;
    case (c)
      3'b000: begin
        s    = {1'b0, x} + {1'b0, y};
        e.r  = s[W-1:0];
        e.co = s[W];
        e.ov = (x[W-1] == y[W-1]) && (e.r[W-1] != x[W-1]);
      end
      3'b001, 3'b011: begin
        s    = {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, 1'b1};
        e.co = s[W];
        e.ov = (x[W-1] != y[W-1]) && (s[W-1] != x[W-1]);
        if (c == 3'b001) e.r = s[W-1:0];
        else e.r = {{(W-1){1'b0}}, ($signed(x) < $signed(y))};
      end
      3'b010: e.r = x ^ y;
      3'b100: e.r = x & y;
      3'b101: e.r = ~(x & y);
      3'b110: e.r = ~(x | y);
      default: e.r = x | y;
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  function automatic logic bit_at(input logic [W-1:0] x, input int k);
    logic [W-1:0] t;
    t = x >> k;
    return t[0];
  endfunction

  // Carry into bit k: sum of the low k bits plus the initial carry
  function automatic logic cin_at(input logic [2:0] c,
                                  input logic [W-1:0] x,
                                  input logic [W-1:0] y, input int k);
    logic [W-1:0] m;
    logic [W-1:0] yy;
    logic         c0;
    logic [W:0]   s;
    logic [W:0]   t;
    c0 = (c != 3'b000);
    yy = c0 ? ~y : y;
    m  = (W'(1) << k) - W'(1);
    s  = {1'b0, x & m} + {1'b0, yy & m} + {{W{1'b0}}, c0};
    t  = s >> k;
    return t[0];
  endfunction

  // Scoreboard monitor: compare on every accepted result
  always @(negedge clk) begin
    if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out: got result %0h expected none",
                 result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", 64'(result), 64'(e.r));
        chk("carryout", 64'(carryout), 64'(e.co));
        chk("overflow", 64'(overflow), 64'(e.ov));
        chk("zero", 64'(zero), 64'(e.z));
      end
    end
  end

  task automatic do_op(input logic [2:0] c, input logic [W-1:0] x,
                       input logic [W-1:0] y, input int stall);
    exp_t e;
    int   k;
    int   lat;
    @(posedge clk);
    #1;
    k = 0;
    while (in_ready !== 1'b1 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("in_ready_idle", 64'(in_ready), 64'(1));
    a         = x;
    b         = y;
    command   = c;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    e = model(c, x, y);
    sb.push_back(e);
    lat = (c == 3'b011) ? W + 1 : W;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    command  = 3'($urandom);
    k = 0;
    while (out_valid !== 1'b1 && k < 100) begin
      if (k < W) begin
        chk("slice_command", 64'(slice_command), 64'(c));
        chk("slice_a", 64'(slice_a), 64'(bit_at(x, k)));
        chk("slice_b", 64'(slice_b), 64'(bit_at(y, k)));
        if (is_arith(c))
          chk("slice_carryin", 64'(slice_carryin),
              64'(cin_at(c, x, y, k)));
      end
      @(posedge clk);
      #1;
      k++;
    end
    chk("latency", 64'(k), 64'(lat));
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      a        = $urandom;
      b        = $urandom;
      command  = 3'($urandom);
      chk("in_ready_done", 64'(in_ready), 64'(0));
      @(posedge clk);
      #1;
      chk("hold_valid", 64'(out_valid), 64'(1));
      chk("hold_result", 64'(result), 64'(e.r));
      chk("hold_flags", 64'({carryout, overflow, zero}),
          64'({e.co, e.ov, e.z}));
    end
    out_ready = 1'b1;
    in_valid  = (stall > 0);
    @(posedge clk);
    #1;
    chk("valid_drop", 64'(out_valid), 64'(0));
    chk("back_to_idle", 64'(in_ready), 64'(1));
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic chk_cleared(input string nm);
    chk({nm, "_ready"}, 64'(in_ready), 64'(1));
    chk({nm, "_valid"}, 64'(out_valid), 64'(0));
    chk({nm, "_result"}, 64'(result), 64'(0));
    chk({nm, "_flags"}, 64'({carryout, overflow, zero}), 64'(0));
    chk({nm, "_slice"}, 64'({slice_a, slice_b, slice_carryin,
                             slice_command}), 64'(0));
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    command   = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk_cleared("reset");

    do_op(3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    do_op(3'b001, 32'h8000_0000, 32'h0000_0001, 0);
    do_op(3'b011, 32'hFFFF_FFFB, 32'h0000_0003, 0);
    do_op(3'b011, 32'h7FFF_FFFF, 32'h8000_0000, 0);
    do_op(3'b101, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
    do_op(3'b010, 32'h1234_5678, 32'h0F0F_0F0F, 5);
    do_op(3'b011, 32'h0000_0005, 32'h0000_0005, 3);

    // Abort an ADD at bit 10 with a one-edge reset
    @(posedge clk);
    #1;
    a        = 32'h1234_5678;
    b        = 32'h1111_1111;
    command  = 3'b000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk_cleared("midrun");
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk);
      #1;
      chk("no_valid_after_abort", 64'(out_valid), 64'(0));
    end

    do_op(3'b000, 32'd3, 32'd4, 0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]   rc;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      rc = 3'($urandom);
      ra = $urandom;
      rb = (i % 8 == 0) ? ra : $urandom;
      do_op(rc, ra, rb, int'($urandom_range(0, 3)));
    end

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_serial_sequencer.md
Name: alu_serial_sequencer

Overview:
- Multi-cycle controller that runs a full WIDTH-bit ALU operation through one external 1-bit ALU slice, LSB first, one bit per clock.
- Upstream of the slice, it drives the operand bits, carry-in and command each cycle.
- Downstream of the slice, it captures each result bit and the carry-out, then assembles the word result and flags.
- It applies the SLT fix-up and presents the result over a valid/ready handshake.

Parameters:
- WIDTH, 32, operand/result width in bits (legal range 2..64).
- IDXW, 6, width of the bit-index counter (must satisfy 2^IDXW >= WIDTH).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- command  input  3  000 ADD, 001 SUB, 010 XOR, 011 SLT, 100 AND, 101 NAND, 110 NOR, 111 OR.
- slice_a  output  1  A bit to the slice.
- slice_b  output  1  B bit to the slice.
- slice_carryin  output  1  carry into the slice.
- slice_command  output  3  command to the slice.
- slice_result  input  1  slice result bit; combinational, valid in the same cycle.
- slice_carryout  input  1  slice carry-out; combinational, same cycle.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  final word.
- carryout  output  1  carry out of the MSB.
- overflow  output  1  signed overflow.
- zero  output  1  result == 0.

Behaviour:
- Reset: synchronous, active-low. When reset_n is low at an edge:
  - state <= IDLE.
  - All registers cleared: result=0, carryout=0, overflow=0, zero=0, out_valid=0, bit index=0.
  - slice_* outputs = 0.
  - Reset wins over every other event, including mid-RUN and in DONE; any in-flight operation is discarded with no output.
- States: IDLE, RUN, SLTFIX, DONE.
- IDLE:
  - in_ready=1; slice_* outputs driven 0.
  - On in_valid=1: latch a, b, command; idx<=0; carry_reg<=1 for SUB/SLT, else 0; go to RUN.
- RUN (one bit per cycle):
  - Outputs: slice_a=A[idx], slice_b=B[idx], slice_carryin=carry_reg, slice_command=latched command (unchanged for every bit).
  - At the edge: res_reg[idx]<=slice_result; carry_reg<=slice_carryout; idx<=idx+1.
  - On idx==WIDTH-1:
    - carryout<=slice_carryout.
    - overflow<=carry_reg XOR slice_carryout, where carry_reg is the carry into the MSB.
    - Next state is SLTFIX if command==011, else DONE.
- Flag masking: for XOR/AND/NAND/NOR/OR, carryout and overflow are forced to 0.
- SLTFIX (one cycle):
  - result <= {WIDTH-1 zeros, res_reg[WIDTH-1] XOR overflow}.
  - carryout and overflow keep their computed values (not masked).
  - Go to DONE.
- DONE:
  - out_valid=1. result, carryout, overflow and zero are held stable until accepted.
  - zero is computed from the final result, after the SLT fix-up.
  - On out_ready=1: go to IDLE, out_valid falls at that edge.
  - in_ready=0 throughout DONE; in_valid during DONE is ignored, including when it coincides with out_ready.
- Busy behaviour: in_valid in RUN/SLTFIX/DONE is ignored. a, b and command may change freely after acceptance.
- Latency, counted from the acceptance edge (first rising edge with in_valid=1 in IDLE):
  - out_valid is high after edge WIDTH for non-SLT commands.
  - out_valid is high after edge WIDTH+1 for SLT.
  - Minimum issue interval is WIDTH+2 cycles (non-SLT with out_ready held high).
- Arithmetic:
  - Two's complement, modulo 2^WIDTH.
  - SUB/SLT rely on the slice inverting B when command is 001/011, plus the initial carry of 1.
- Index counter: never wraps during an operation; reset to 0 on each acceptance.

Test Plan:
- ADD, a=0xFFFFFFFF, b=0x00000001 -> result 0x00000000, carryout=1, overflow=0, zero=1; out_valid rises exactly 32 edges after acceptance.
- SUB, a=0x80000000, b=0x00000001 -> result 0x7FFFFFFF, carryout=1, overflow=1, zero=0.
- SLT, a=0xFFFFFFFB (-5), b=0x00000003 -> result 0x00000001; SLT, a=0x7FFFFFFF, b=0x80000000 -> result 0x00000000 (overflow path). Both deliver out_valid 33 edges after acceptance.
- NAND, a=0xF0F0F0F0, b=0xFF00FF00 -> result 0x0FFF0FFF, carryout=0, overflow=0. In the same run, check slice_command stays 101 and slice_a/slice_b track bit idx every RUN cycle.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid -> outputs stable, in_ready=0, no new acceptance. Then out_ready=1 -> IDLE next edge, and a new request is accepted on the following edge.
- Reset mid-RUN: reset_n=0 for one edge at idx=10 of an ADD -> IDLE, all outputs 0, no out_valid. A fresh ADD 3+4 -> result 7.
